tx_serial_rx: RTL and testbench
===============================

Name: tx_serial_rx

Overview:
- Receive end of the serial TX link: recovers framed words from the single-bit line driven by the transmitter.
- Samples each bit at mid-period, checks parity and stop bit, and queues words with error flags in a small FIFO.
- Presents queued words downstream on a valid/ready handshake.
- Sits on the receive side of tx_interface, mirroring the transmitter that drives the line.

Parameters:
- DATA_W, 8, data bits per frame, sent LSB first; legal range 5..16.
- CLKS_PER_BIT, 16, clk cycles per bit period; legal range ≥4, even.
- PARITY_EN, 1, 1 = even parity bit follows data; 0 = no parity bit.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rx_d  in  1  serial line; idles high.
- rx_data  out  DATA_W  FIFO head data.
- rx_perr  out  1  FIFO head parity error flag.
- rx_ferr  out  1  FIFO head framing error flag.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  downstream accepts head.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (sampled on clk while reset=1): FSM=IDLE, FIFO empty, counters 0, sync flops=1.
- Output reset values: rx_data=0, rx_perr=0, rx_ferr=0, rx_valid=0, overrun=0, busy=0.
- Reset mid-frame aborts the frame; no partial word is queued.
- Synchronizer: rx_d passes through 2 flops to give rx_s. Edge detection uses rx_s and its previous value.
- Frame format: start(0), DATA_W data bits LSB first, parity if PARITY_EN (even: XOR of data and parity = 0), stop(1).
- FSM states and transitions:
  - IDLE: on rx_s falling edge, load cnt=CLKS_PER_BIT/2-1 and go to START.
  - START: when cnt=0, sample rx_s. If 1, false start: return to IDLE, nothing queued. If 0, load cnt=CLKS_PER_BIT-1 and go to DATA.
  - DATA: when cnt=0, shift rx_s into bit[idx] and reload cnt. After bit DATA_W-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: when cnt=0, sample, compute perr, reload cnt, go to STOP.
  - STOP: when cnt=0, sample; ferr = (sample==0). Issue push request in that same cycle. Go to IDLE if sample=1, else WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then IDLE. A held-low line (break) never produces a second frame.
- All sampling is at mid-bit. The cnt decrement happens every cycle outside IDLE and WAIT_IDLE.
- Latency: the frame is visible on rx_valid 1 cycle after the stop sample cycle.
- Total from line falling edge to rx_valid: 2 (sync) + CLKS_PER_BIT/2 + (DATA_W+PARITY_EN+1)*CLKS_PER_BIT + 1 cycles.
- FIFO entry = {ferr, perr, data}. rx_* outputs show the head combinationally from storage.
- Pop occurs when rx_valid & rx_ready. rx_data is don't-care when rx_valid=0 but must not be X after reset.
- Push when full and no pop in the same cycle: frame dropped, overrun=1 for exactly that cycle, FIFO contents unchanged.
- Push when full with a pop in the same cycle: pop and push both take effect, no overrun, count unchanged.
- Push when empty: no same-cycle bypass; rx_valid rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Occupancy uses a count of width log2(FIFO_DEPTH)+1.
- rx_ready asserted while rx_valid=0 has no effect.
- Errored frames are queued, never dropped, with their flags set.

Test Plan:
- Frame 0xA5 (CLKS_PER_BIT=4, DATA_W=8, PARITY_EN=1), parity=0, stop=1, rx_ready=1 -> rx_valid 1 cycle high with rx_data=0xA5, perr=0, ferr=0, at 2+2+40+1=45 cycles after the falling edge.
- Frame 0x01 sent with parity bit 0 (wrong) -> rx_data=0x01, rx_perr=1, rx_ferr=0.
- Frame 0x3C with stop=0, then line held low for 20 cycles, then high -> one entry with rx_ferr=1; no further entries; busy stays 1 until the line goes high.
- Glitch: rx_d low for 1 cycle only -> START sample reads 1, FSM returns to IDLE, FIFO stays empty.
- rx_ready=0, send 5 frames 0x10..0x14 (FIFO_DEPTH=4) -> overrun pulses once on the 5th stop; pops then return 0x10, 0x11, 0x12, 0x13.
- Assert reset during DATA bit 3 of a frame -> all outputs at reset values next cycle; a subsequent clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/tx_serial_rx.sv
// Receive end of the serial TX link.
// Recovers start/data/parity/stop frames from rx_d by sampling at mid-bit,
// then queues {ferr, perr, data} words in a small FIFO that is presented
// downstream on a valid/ready handshake.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | line idle, watching for a falling edge on rx_s
// S_START     | half a bit period in; confirms the start bit is still low
// S_DATA      | samples DATA_W data bits, LSB first, one per bit period
// S_PARITY    | samples the even-parity bit and records a parity error
// S_STOP      | samples the stop bit; the completed word is pushed here
// S_WAIT_IDLE | stop bit was low (break); waits for the line to go high
module tx_serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_d,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_W + 2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   shift_q;
  logic                perr_q;

  logic                rx_meta_q;
  logic                rx_s_q;
  logic                rx_prev_q;

  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W:0]      count_q;

  logic                fall_d;
  logic                push_d;
  logic                pop_d;
  logic                full_d;
  logic                wr_en_d;
  logic [ENT_W-1:0]    word_d;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_d;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall_d = rx_prev_q & ~rx_s_q;

  // Frame FSM: mid-bit sampling driven by a down-counter that reloads per bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall_d) begin
            cnt_q   <= CNT_HALF;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q   <= CNT_BIT;
              idx_q   <= '0;
              perr_q  <= 1'b0;
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shift_q[idx_q] <= rx_s_q;
            cnt_q          <= CNT_BIT;
            if (idx_q == IDX_LAST) begin
              state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == '0) begin
            // Even parity: data bits XOR parity bit must be zero.
            perr_q  <= ^{shift_q, rx_s_q};
            cnt_q   <= CNT_BIT;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            state_q <= rx_s_q ? S_IDLE : S_WAIT_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The stop-bit sample cycle writes straight into the FIFO so the word is
  // visible one cycle later; a low stop bit marks a framing error.
  assign push_d  = (state_q == S_STOP) && (cnt_q == '0);
  assign word_d  = {~rx_s_q, perr_q, shift_q};
  assign pop_d   = rx_valid & rx_ready;
  assign full_d  = (count_q == CNT_FULL);
  assign wr_en_d = push_d & (~full_d | pop_d);

  // Output FIFO storage and pointers; a push while full without a pop is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en_d) begin
        mem_q[wr_ptr_q] <= word_d;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_d) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en_d, pop_d})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign {rx_ferr, rx_perr, rx_data} = mem_q[rd_ptr_q];
  assign rx_valid = (count_q != '0);
  assign overrun  = push_d & full_d & ~pop_d;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_serial_rx.sv
// Bench for tx_serial_rx: directed frames from the test plan followed by
// random frames, all checked against a queue-based model of received words.
module tb_tx_serial_rx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int PEN = 1;
  localparam int FD  = 4;

  logic          clk;
  logic          reset;
  logic          rx_d;
  logic [DW-1:0] rx_data;
  logic          rx_perr;
  logic          rx_ferr;
  logic          rx_valid;
  logic          rx_ready;
  logic          overrun;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_seen = 0;
  int exp_ovr  = 0;
  bit rand_rdy = 0;
  bit mon_en   = 0;

  // expected entries: {ferr, perr, data}
  logic [DW+1:0] exp_q[$];

  tx_serial_rx #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(PEN), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .rx_d(rx_d),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line model of a received word: even parity over data+parity, stop must be 1.
  task automatic model_push(input logic [DW-1:0] data, input logic pbit, input logic stop);
    logic perr;
    logic ferr;
    perr = 1'(($countones(data) + int'(pbit)) % 2);
    ferr = ~stop;
    if (exp_q.size() >= FD) exp_ovr++;
    else exp_q.push_back({ferr, perr, data});
  endtask

  // Each bit is held for CPB clocks; tasks enter and leave #1 after a rising edge.
  task automatic send_bit(input logic b);
    rx_d = b;
    for (int i = 0; i < CPB; i++) begin
      @(posedge clk);
      #1;
      if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    rx_d = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(data[i]);
    send_bit(pbit);
    send_bit(stop);
    model_push(data, pbit, stop);
  endtask

  function automatic logic even_par(input logic [DW-1:0] d);
    return 1'($countones(d) % 2);
  endfunction

  // Scoreboard: every handshake must pop the oldest expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (overrun) ovr_seen++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 32'(rx_valid), 32'(0));
        end else begin
          logic [DW+1:0] e;
          e = exp_q.pop_front();
          check_eq("rx_data", 32'(rx_data), 32'(e[DW-1:0]));
          check_eq("rx_perr", 32'(rx_perr), 32'(e[DW]));
          check_eq("rx_ferr", 32'(rx_ferr), 32'(e[DW+1]));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_d     = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid",   32'(rx_valid), 32'(0));
    check_eq("rst_data",    32'(rx_data),  32'(0));
    check_eq("rst_perr",    32'(rx_perr),  32'(0));
    check_eq("rst_ferr",    32'(rx_ferr),  32'(0));
    check_eq("rst_overrun", 32'(overrun),  32'(0));
    check_eq("rst_busy",    32'(busy),     32'(0));
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(5);

    // 0xA5 clean frame: valid appears 45 cycles after the falling edge, for one cycle.
    send_frame(8'hA5, even_par(8'hA5), 1'b1);
    check_eq("lat_early", 32'(rx_valid), 32'(0));
    @(posedge clk); #1;
    check_eq("lat_valid", 32'(rx_valid), 32'(1));
    check_eq("lat_data",  32'(rx_data),  32'hA5);
    @(posedge clk); #1;
    check_eq("lat_drop",  32'(rx_valid), 32'(0));
    idle(4);

    // 0x01 with a wrong parity bit.
    send_frame(8'h01, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_eq("perr_flag", 32'(rx_perr), 32'(1));
    check_eq("perr_ferr", 32'(rx_ferr), 32'(0));
    idle(4);

    // 0x3C with a low stop bit, then a 20-cycle break.
    send_frame(8'h3C, even_par(8'h3C), 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_eq("break_busy", 32'(busy), 32'(1));
    end
    idle(4);
    check_eq("break_idle", 32'(busy), 32'(0));
    check_eq("break_single", 32'(rx_valid), 32'(0));

    // One-cycle glitch: false start, nothing queued.
    rx_d = 1'b0;
    @(posedge clk); #1;
    rx_d = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("glitch_busy", 32'(busy), 32'(1));
    repeat (2) @(posedge clk);
    #1;
    check_eq("glitch_abort", 32'(busy), 32'(0));
    idle(10);
    check_eq("glitch_empty", 32'(rx_valid), 32'(0));

    // Overrun: five frames into a four-deep FIFO with no reader.
    rx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [DW-1:0] d;
      d = 8'(8'h10 + k);
      send_frame(d, even_par(d), 1'b1);
      if (k == 4) begin
        check_eq("ovr_pulse", 32'(overrun), 32'(1));
        @(posedge clk); #1;
        check_eq("ovr_end", 32'(overrun), 32'(0));
      end
      idle(3);
    end
    check_eq("ovr_count", 32'(ovr_seen), 32'(1));
    check_eq("ovr_head", 32'(rx_data), 32'h10);
    rx_ready = 1'b1;
    idle(8);
    check_eq("ovr_drained", 32'(exp_q.size()), 32'(0));
    check_eq("ovr_empty", 32'(rx_valid), 32'(0));

    // Reset during DATA bit 3 with a word still queued.
    rx_ready = 1'b0;
    send_frame(8'h77, even_par(8'h77), 1'b1);
    idle(3);
    check_eq("pre_rst_head", 32'(rx_data), 32'h77);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check_eq("pre_rst_busy", 32'(busy), 32'(1));
    reset = 1'b1;
    rx_d  = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_valid", 32'(rx_valid), 32'(0));
    check_eq("mid_rst_data",  32'(rx_data),  32'(0));
    check_eq("mid_rst_busy",  32'(busy),     32'(0));
    check_eq("mid_rst_flags", 32'({rx_perr, rx_ferr, overrun}), 32'(0));
    exp_q.delete();
    reset    = 1'b0;
    rx_ready = 1'b1;
    idle(5);
    send_frame(8'h5A, even_par(8'h5A), 1'b1);
    idle(5);
    check_eq("post_rst_drained", 32'(exp_q.size()), 32'(0));

    // Random frames with random reader back-pressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 24; k++) begin
      logic [DW-1:0] d;
      logic pb;
      logic sb;
      d  = 8'($urandom);
      pb = even_par(d) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 7) != 0);
      send_frame(d, pb, sb);
      if (!sb) begin
        rx_d = 1'b0;
        for (int j = 0; j < int'($urandom_range(0, 10)); j++) begin
          @(posedge clk); #1;
          rx_ready = 1'($urandom_range(0, 1));
        end
      end
      idle(int'($urandom_range(2, 8)));
    end
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    idle(20);
    check_eq("final_drained", 32'(exp_q.size()), 32'(0));
    check_eq("final_empty",   32'(rx_valid), 32'(0));
    check_eq("final_ovr",     32'(ovr_seen), 32'(exp_ovr));
    check_eq("final_busy",    32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
